// File: rtl/multiplier.sv
// -----------------------------------------------------------------------------
// multiplier
//
// Unsigned WIDTH_A x WIDTH_B array multiplier with a combinational product
// output and a one-cycle registered copy qualified by a valid flag.
//
// The product is formed from AND-gate partial products. These are summed row
// by row with ripple-carry adder rows that are generated from the widths.
//
// Ports
//   clk       : rising-edge clock for the registered path
//   rst       : asynchronous active-high reset (clears P_q and out_valid)
//   A         : unsigned multiplicand, WIDTH_A bits
//   B         : unsigned multiplier, WIDTH_B bits
//   in_valid  : captures P into P_q on the next rising edge
//   P         : combinational product A*B, WIDTH_A+WIDTH_B bits
//   P_q       : registered product, held while in_valid is low
//   out_valid : P_q was loaded on the most recent edge
// -----------------------------------------------------------------------------
module multiplier #(
    parameter int WIDTH_A = 2,
    parameter int WIDTH_B = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH_A-1:0]         A,
    input  logic [WIDTH_B-1:0]         B,
    input  logic                       in_valid,
    output logic [WIDTH_A+WIDTH_B-1:0] P,
    output logic [WIDTH_A+WIDTH_B-1:0] P_q,
    output logic                       out_valid
);

    localparam int PW = WIDTH_A + WIDTH_B;

    // Partial product row j holds A AND B[j].
    logic [WIDTH_A-1:0] pp  [WIDTH_B];
    // Running sum after row j. Bit 0 is final product bit j.
    // Bits WIDTH_A:1 carry forward into row j+1.
    logic [WIDTH_A:0]   acc [WIDTH_B];

    for (genvar j = 0; j < WIDTH_B; j++) begin : g_pp
        for (genvar i = 0; i < WIDTH_A; i++) begin : g_and
            assign pp[j][i] = A[i] & B[j];
        end
    end

    assign acc[0] = {1'b0, pp[0]};

    // Each row adds the shifted running sum to the next partial product.
    // The carry into bit 0 is tied low, so that position acts as a half adder.
    for (genvar j = 1; j < WIDTH_B; j++) begin : g_row
        logic [WIDTH_A-1:0] x;
        logic [WIDTH_A-1:0] s;
        logic [WIDTH_A:0]   c;

        assign x    = acc[j-1][WIDTH_A:1];
        assign c[0] = 1'b0;

        for (genvar i = 0; i < WIDTH_A; i++) begin : g_fa
            assign s[i]   = x[i] ^ pp[j][i] ^ c[i];
            assign c[i+1] = (x[i] & pp[j][i]) | (c[i] & (x[i] ^ pp[j][i]));
        end

        assign acc[j] = {c[WIDTH_A], s};
    end

    // Low product bits are retired one per row. The final row supplies the top bits.
    for (genvar j = 0; j < WIDTH_B; j++) begin : g_plo
        assign P[j] = acc[j][0];
    end
    assign P[PW-1:WIDTH_B] = acc[WIDTH_B-1][WIDTH_A:1];

    // Registered path
    logic [PW-1:0] pq_q, pq_d;
    logic          vld_q, vld_d;

    always_comb begin
        pq_d  = pq_q;
        vld_d = in_valid;
        if (in_valid) begin
            pq_d = P;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pq_q  <= '0;
            vld_q <= 1'b0;
        end else begin
            pq_q  <= pq_d;
            vld_q <= vld_d;
        end
    end

    assign P_q       = pq_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_multiplier.sv
module tb_multiplier;

    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic rst    = 1'b0;

    logic [1:0]  a2 = '0, b2 = '0;
    logic        v2 = 1'b0;
    logic [3:0]  p2, pq2;
    logic        ov2;

    logic [7:0]  a8 = '0, b8 = '0;
    logic        v8 = 1'b0;
    logic [15:0] p8, pq8;
    logic        ov8;

    int tests = 0;
    int fails = 0;
    int q2[$];
    int q8[$];

    multiplier u_d2 (
        .clk(clk), .rst(rst), .A(a2), .B(b2), .in_valid(v2),
        .P(p2), .P_q(pq2), .out_valid(ov2)
    );

    multiplier #(.WIDTH_A(8), .WIDTH_B(8)) u_d8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .in_valid(v8),
        .P(p8), .P_q(pq8), .out_valid(ov8)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the expected product is plain integer multiplication.
    task automatic issue2(input int a, input int b, input bit v);
        a2 = a[1:0];
        b2 = b[1:0];
        v2 = v;
        if (v && !rst) q2.push_back(a * b);
    endtask

    task automatic issue8(input int a, input int b, input bit v);
        a8 = a[7:0];
        b8 = b[7:0];
        v8 = v;
        if (v && !rst) q8.push_back(a * b);
    endtask

    // Monitor: whenever a registered output is flagged valid, it must match the oldest
    // expected product. When it is not valid, nothing may be outstanding.
    always @(posedge clk) begin
        #1;
        if (ov2) begin
            if (q2.size() == 0) check("pq2_unexpected_valid", 32'd1, 32'd0);
            else                check("pq2_scoreboard", {28'd0, pq2}, q2.pop_front());
        end else begin
            check("pq2_lost_capture", q2.size(), 32'd0);
        end
        if (ov8) begin
            if (q8.size() == 0) check("pq8_unexpected_valid", 32'd1, 32'd0);
            else                check("pq8_scoreboard", {16'd0, pq8}, q8.pop_front());
        end else begin
            check("pq8_lost_capture", q8.size(), 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    int ta[9] = '{3, 2, 1, 3, 2, 1, 3, 2, 1};
    int tb[9] = '{1, 2, 3, 2, 3, 1, 3, 1, 2};
    int te[9] = '{3, 4, 3, 6, 6, 1, 9, 2, 2};
    int sa[4] = '{2, 3, 1, 3};
    int sb[4] = '{3, 2, 1, 3};
    int se[4] = '{6, 6, 1, 9};

    initial begin
        // Reset state, clock stopped
        #1 rst = 1'b1;
        #1;
        check("reset_pq2", {28'd0, pq2}, 32'd0);
        check("reset_ov2", {31'd0, ov2}, 32'd0);
        check("reset_pq8", {16'd0, pq8}, 32'd0);
        check("reset_ov8", {31'd0, ov8}, 32'd0);

        // Combinational sweep with no clock edges
        for (int k = 0; k < 9; k++) begin
            a2 = ta[k][1:0];
            b2 = tb[k][1:0];
            #10;
            check("comb_table", {28'd0, p2}, te[k]);
        end
        a2 = 2'd0; b2 = 2'd3; #10; check("zero_a", {28'd0, p2}, 32'd0);
        a2 = 2'd3; b2 = 2'd0; #10; check("zero_b", {28'd0, p2}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                a2 = a[1:0];
                b2 = b[1:0];
                #10;
                check("comb_exhaustive", {28'd0, p2}, a * b);
            end
        end

        // 8x8 instance
        a8 = 8'd255; b8 = 8'd255; #10;
        check("comb8_max", {16'd0, p8}, 32'd65025);
        for (int k = 0; k < 1000; k++) begin
            int ra, rb;
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            a8 = ra[7:0];
            b8 = rb[7:0];
            #1;
            check("comb8_random", {16'd0, p8}, ra * rb);
        end
        check("reset_held_pq2", {28'd0, pq2}, 32'd0);

        // Registered path
        clk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        issue2(3, 3, 1);
        issue8(255, 255, 1);
        @(negedge clk);
        check("reg_first_ov2", {31'd0, ov2}, 32'd1);
        check("reg_first_pq2", {28'd0, pq2}, 32'd9);
        issue2(1, 2, 0);
        issue8(7, 9, 0);
        @(negedge clk);
        check("reg_hold_pq2", {28'd0, pq2}, 32'd9);
        check("reg_hold_ov2", {31'd0, ov2}, 32'd0);
        check("reg_hold_p2", {28'd0, p2}, 32'd2);
        check("reg_hold_pq8", {16'd0, pq8}, 32'd65025);

        // Async reset between edges
        issue2(3, 3, 1);
        @(negedge clk);
        check("pre_rst_pq2", {28'd0, pq2}, 32'd9);
        check("pre_rst_ov2", {31'd0, ov2}, 32'd1);
        a2 = 2'd2; b2 = 2'd3; v2 = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("async_rst_pq2", {28'd0, pq2}, 32'd0);
        check("async_rst_ov2", {31'd0, ov2}, 32'd0);
        check("async_rst_p2", {28'd0, p2}, 32'd6);
        check("async_rst_pq8", {16'd0, pq8}, 32'd0);
        @(negedge clk);
        check("rst_held_pq2", {28'd0, pq2}, 32'd0);
        check("rst_held_ov2", {31'd0, ov2}, 32'd0);

        // Streaming after reset release
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            issue2(sa[k], sb[k], 1);
            @(negedge clk);
            check("stream_ov2", {31'd0, ov2}, 32'd1);
            check("stream_pq2", {28'd0, pq2}, se[k]);
        end
        issue2(0, 0, 0);

        // Random traffic, both instances
        for (int k = 0; k < 300; k++) begin
            issue2($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            issue8($urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
            @(negedge clk);
        end

        // Mid-stream reset discards the captured product
        issue2(1, 3, 1);
        issue8(0, 0, 0);
        @(negedge clk);
        check("mid_pre_pq2", {28'd0, pq2}, 32'd3);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ov2", {31'd0, ov2}, 32'd0);
        check("mid_rst_pq2", {28'd0, pq2}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue2(2, 2, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid_idle_ov2", {31'd0, ov2}, 32'd0);
            check("mid_idle_pq2", {28'd0, pq2}, 32'd0);
        end
        issue2(2, 2, 1);
        @(negedge clk);
        check("mid_recap_ov2", {31'd0, ov2}, 32'd1);
        check("mid_recap_pq2", {28'd0, pq2}, 32'd4);
        issue2(0, 0, 0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 Parameter WIDTH_A, default 2: operand A width in bits, legal range 2..16.
REQ-002 Parameter WIDTH_B, default 2: operand B width in bits, legal range 2..16.
REQ-003 Port clk, input, 1: single clock; all registers update on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port A, input, WIDTH_A: unsigned multiplicand.
REQ-006 Port B, input, WIDTH_B: unsigned multiplier.
REQ-007 Port in_valid, input, 1: A/B qualifier for the registered path.
REQ-008 Port P, output, WIDTH_A+WIDTH_B: combinational product of A and B.
REQ-009 Port P_q, output, WIDTH_A+WIDTH_B: registered product.
REQ-010 Port out_valid, output, 1: P_q holds a product captured with in_valid=1.

Function
REQ-011 P SHALL equal A*B, unsigned, full width, no truncation or saturation, for every input combination.
REQ-012 P SHALL be purely combinational: it settles within the same evaluation as an A/B change, with no clock edge needed.
REQ-013 P SHALL be independent of clk, rst and in_valid.
REQ-014 The product SHALL be built as an explicit array multiplier:
- WIDTH_A x WIDTH_B AND-gate partial products.
- Rows accumulated by ripple-carry full/half-adder rows generated from the parameters.
- No behavioural '*' operator.
REQ-015 Maximum operands SHALL produce (2^WIDTH_A-1)*(2^WIDTH_B-1) exactly; with the defaults, 3*3 = 9.
REQ-016 Any zero operand SHALL yield P = 0.
REQ-017 On each rising clk edge with in_valid=1, P_q SHALL load the current P and out_valid SHALL be set to 1 (latency one cycle).
REQ-018 On each rising clk edge with in_valid=0:
- P_q SHALL hold its value.
- out_valid SHALL be cleared to 0.
REQ-019 Back-to-back in_valid pulses SHALL be accepted every cycle. There is no backpressure and no stall.
REQ-020 A/B changes without in_valid SHALL affect P only, never P_q.

Reset
REQ-021 rst=1 SHALL immediately, without waiting for clk, force P_q = 0 and out_valid = 0.
REQ-022 While rst=1:
- Registers SHALL hold their reset values regardless of in_valid.
- P SHALL continue to track A*B.
REQ-023 On rst deassertion, the first rising edge with in_valid=1 SHALL capture normally. No extra cycles are lost.
REQ-024 Reset asserted mid-stream SHALL discard any captured product; out_valid SHALL read 0 until the next valid capture.

Verification
REQ-025 Defaults, combinational sweep:
- A=3,B=1 -> P=3.
- A=2,B=2 -> P=4.
- A=1,B=3 -> P=3.
- A=3,B=2 -> P=6.
- A=2,B=3 -> P=6.
- A=1,B=1 -> P=1.
- A=3,B=3 -> P=9.
- A=2,B=1 -> P=2.
- A=1,B=2 -> P=2.
- Each checked 10 ns after the change, with no clock edges.
REQ-026 Zero operands: A=0,B=3 -> P=0; A=3,B=0 -> P=0; exhaustive 16-pair sweep matches A*B.
REQ-027 Registered path:
- in_valid=1 with A=3,B=3 at edge n -> after edge n, P_q=9 and out_valid=1.
- in_valid=0 at edge n+1 -> P_q stays 9, out_valid=0.
REQ-028 Async reset: with P_q=9 and out_valid=1, assert rst between clock edges -> P_q=0 and out_valid=0 before the next edge. P still equals the current A*B.
REQ-029 Streaming: in_valid=1 for 4 consecutive cycles with (2,3),(3,2),(1,1),(3,3) -> P_q = 6, 6, 1, 9 on successive edges, with out_valid=1 throughout.
REQ-030 Parameter check: WIDTH_A=8, WIDTH_B=8 with A=255,B=255 -> P=65025; random sweep of 1000 pairs matches A*B.
